// File: rtl/divider_pkg.sv
// divider_pkg
//   Shared types and defaults for the divided-clock tap selector.
//   - tap_sel_state_t : selector FSM states
//   - NUM_TAPS_DEFAULT, SEL_W_DEFAULT : default tap count and select width
//   - TIMEOUT_DEFAULT, TIMER_W : default wait-state timeout and its counter width
//   - timer_width() : counter width for an arbitrary timeout (never zero)
package divider_pkg;

  localparam int NUM_TAPS_DEFAULT = 8;
  localparam int SEL_W_DEFAULT    = $clog2(NUM_TAPS_DEFAULT);
  localparam int TIMEOUT_DEFAULT  = 512;
  localparam int TIMER_W          = $clog2(TIMEOUT_DEFAULT);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    WAIT_OLD_LOW = 2'd1,
    WAIT_NEW_LOW = 2'd2
  } tap_sel_state_t;

  // A timeout of 1 would give a zero-width counter, so clamp to one bit.
  function automatic int timer_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/divider_tap_select_timer.sv
// tap_wait_timer
//   Counts cycles spent in a selector wait state and flags when the
//   pending transition must be forced.
//   Ports:
//     clk, rst_n : clock and synchronous active-low reset
//     clear      : zero the count (takes priority over enable)
//     enable     : advance the count by one
//     expired    : count has reached TIMEOUT-1
module tap_wait_timer
  import divider_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = timer_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturate at LAST so a stuck enable can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/divider_tap_select.sv
// divider_tap_select
//   Glitch-free selector for the divided-clock taps. Forwards one tap on a
//   registered cout, changes taps via a valid/ready request without runt
//   pulses, and emits a one-cycle tick on every cout rising edge.
//   Ports:
//     clk, rst_n  : clock and synchronous active-low reset
//     taps_in     : divider taps, bit i = divide by 2^(i+1)
//     sel_in      : requested tap index (taken modulo NUM_TAPS)
//     sel_valid   : request strobe
//     sel_ready   : request can be accepted this cycle
//     cout        : selected divided clock, registered
//     tick        : high on the first cycle cout is high
//     cur_sel     : tap currently driving cout
//     switching   : a tap change is in progress
//     timeout_err : sticky, a wait state was abandoned by timeout
module divider_tap_select
  import divider_pkg::*;
#(
  parameter int NUM_TAPS  = NUM_TAPS_DEFAULT,
  parameter int SEL_W     = $clog2(NUM_TAPS),
  parameter int RESET_SEL = 0,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_TAPS-1:0] taps_in,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic                sel_valid,
  output logic                sel_ready,
  output logic                cout,
  output logic                tick,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                switching,
  output logic                timeout_err
);

  localparam logic [SEL_W-1:0] RESET_SEL_V = SEL_W'(RESET_SEL % NUM_TAPS);

  tap_sel_state_t   state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic             cout_q, cout_d;
  logic             tick_q, tick_d;
  logic             timeout_err_q, timeout_err_d;

  logic             accept;
  logic [SEL_W-1:0] sel_mod;
  logic             old_bit;
  logic             new_bit;
  logic             timer_clear;
  logic             timer_enable;
  logic             timer_expired;

  assign sel_ready = (state_q == RUN) & rst_n;
  assign accept    = sel_valid & sel_ready;
  assign sel_mod   = SEL_W'(32'(sel_in) % NUM_TAPS);
  assign old_bit   = taps_in[cur_sel_q];
  assign new_bit   = taps_in[pend_sel_q];

  // The timer restarts on every state change, so each wait state gets its
  // own full budget; it idles cleared while in RUN.
  assign timer_clear  = (state_q == RUN) | (state_d != state_q);
  assign timer_enable = (state_q != RUN);

  tap_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Switch sequence: let the old tap finish its high phase, hold cout low,
  // then hand over only once the new tap is also low so its first high
  // pulse is full width.
  always_comb begin
    state_d       = state_q;
    cur_sel_d     = cur_sel_q;
    pend_sel_d    = pend_sel_q;
    cout_d        = cout_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      RUN: begin
        cout_d = old_bit;
        if (accept && (sel_mod != cur_sel_q)) begin
          pend_sel_d = sel_mod;
          state_d    = WAIT_OLD_LOW;
        end
      end
      WAIT_OLD_LOW: begin
        cout_d = old_bit;
        if (!old_bit || timer_expired) begin
          state_d = WAIT_NEW_LOW;
        end
        if (timer_expired) begin
          timeout_err_d = 1'b1;
        end
      end
      WAIT_NEW_LOW: begin
        cout_d = 1'b0;
        if (!new_bit || timer_expired) begin
          cur_sel_d = pend_sel_q;
          state_d   = RUN;
        end
        if (timer_expired) begin
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cout_d  = 1'b0;
      end
    endcase

    tick_d = cout_d & ~cout_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cur_sel_q     <= RESET_SEL_V;
      pend_sel_q    <= RESET_SEL_V;
      cout_q        <= 1'b0;
      tick_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_sel_q     <= cur_sel_d;
      pend_sel_q    <= pend_sel_d;
      cout_q        <= cout_d;
      tick_q        <= tick_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cout        = cout_q;
  assign tick        = tick_q;
  assign cur_sel     = cur_sel_q;
  assign switching   = (state_q != RUN);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_divider_tap_select.sv
// tb_divider_tap_select
//   Directed bench for divider_tap_select. The taps come from an 8-bit model
//   counter (taps_in[i] = ~cnt[i]), or are forced to all-ones to starve the
//   wait states and exercise the timeout.
module tb_divider_tap_select;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] taps_in;
  logic [2:0] sel_in;
  logic       sel_valid;
  logic       sel_ready;
  logic       cout;
  logic       tick;
  logic [2:0] cur_sel;
  logic       switching;
  logic       timeout_err;

  logic [7:0] cnt;
  logic       force_ff;
  logic [7:0] edge_taps;
  logic [7:0] prev_edge_taps;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign taps_in = force_ff ? 8'hFF : ~cnt;

  divider_tap_select #(
    .NUM_TAPS  (8),
    .SEL_W     (3),
    .RESET_SEL (0),
    .TIMEOUT   (512)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .taps_in     (taps_in),
    .sel_in      (sel_in),
    .sel_valid   (sel_valid),
    .sel_ready   (sel_ready),
    .cout        (cout),
    .tick        (tick),
    .cur_sel     (cur_sel),
    .switching   (switching),
    .timeout_err (timeout_err)
  );

  // Advance one clock. edge_taps holds the tap values the DUT sampled on
  // the edge just taken; the divider model then moves on.
  task automatic step();
    @(posedge clk);
    #1;
    prev_edge_taps = edge_taps;
    edge_taps      = taps_in;
    cnt            = cnt + 8'd1;
  endtask

  task automatic wait_idle(input int max_cycles, output int used);
    used = 0;
    while (switching && used < max_cycles) begin
      step();
      used++;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n     = 1'b0;
    sel_in    = 3'd2;
    sel_valid = 1'b1;
    repeat (3) step();
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
    vectors++; if (cur_sel !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_cur_sel: got %0d expected 0", cur_sel); end
    vectors++; if (sel_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sel_ready: got %b expected 0", sel_ready); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    vectors++; if (switching !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_switching: got %b expected 0", switching); end
    rst_n = 1'b1;
    #1;
    vectors++; if (sel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_sel_ready: got %b expected 1", sel_ready); end
    // The request held through reset is taken on the first RUN edge.
    step();
    sel_valid = 1'b0;
    vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL held_req_switching: got %b expected 1", switching); end
    vectors++; if (sel_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL held_req_sel_ready: got %b expected 0", sel_ready); end
  endtask

  task automatic test_steady();
    int used;
    int highs;
    int ticks;
    logic exp_c;
    logic exp_t;
    $display("[TB] test_steady");
    wait_idle(100, used);
    vectors++; if (used >= 100) begin miscompares++; $display("[TB] FAIL steady_wait: got %0d cycles expected < 100", used); end
    vectors++; if (cur_sel !== 3'd2) begin miscompares++; $display("[TB] FAIL steady_cur_sel: got %0d expected 2", cur_sel); end
    highs = 0;
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_c = edge_taps[2];
      exp_t = edge_taps[2] & ~prev_edge_taps[2];
      vectors++; if (cout !== exp_c) begin miscompares++; $display("[TB] FAIL steady_cout[%0d]: got %b expected %b", i, cout, exp_c); end
      vectors++; if (tick !== exp_t) begin miscompares++; $display("[TB] FAIL steady_tick[%0d]: got %b expected %b", i, tick, exp_t); end
      highs += int'(cout === 1'b1);
      ticks += int'(tick === 1'b1);
    end
    vectors++; if (highs != 8) begin miscompares++; $display("[TB] FAIL steady_high_count: got %0d expected 8", highs); end
    vectors++; if (ticks != 2) begin miscompares++; $display("[TB] FAIL steady_tick_count: got %0d expected 2", ticks); end
  endtask

  task automatic test_switch_2_to_7();
    int n;
    int run_len;
    int runs;
    int exp_len;
    bit done;
    $display("[TB] test_switch_2_to_7");
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++; if (n >= 20) begin miscompares++; $display("[TB] FAIL switch_find_tick: got %0d cycles expected < 20", n); end
    // cout has just risen, so taps_in[2] is high for the accepting edge.
    sel_in    = 3'd7;
    sel_valid = 1'b1;
    vectors++; if (sel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL switch_sel_ready_before: got %b expected 1", sel_ready); end
    run_len = 1;
    runs    = 0;
    done    = 1'b0;
    for (int i = 0; i < 700 && runs < 2; i++) begin
      step();
      if (i == 0) begin
        sel_valid = 1'b0;
        vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL switch_rise: got %b expected 1", switching); end
      end
      if (switching === 1'b1) begin
        vectors++; if (sel_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL switch_sel_ready[%0d]: got %b expected 0", i, sel_ready); end
        vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL switch_tick[%0d]: got %b expected 0", i, tick); end
        if (runs >= 1) begin
          vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL switch_gap_cout[%0d]: got %b expected 0", i, cout); end
        end
      end else begin
        if (!done) begin
          done = 1'b1;
          vectors++; if (cur_sel !== 3'd7) begin miscompares++; $display("[TB] FAIL switch_cur_sel: got %0d expected 7", cur_sel); end
        end
        vectors++; if (cout !== edge_taps[7]) begin miscompares++; $display("[TB] FAIL switch_new_cout[%0d]: got %b expected %b", i, cout, edge_taps[7]); end
      end
      if (cout === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        runs++;
        exp_len = (runs == 1) ? 4 : 128;
        vectors++; if (run_len != exp_len) begin miscompares++; $display("[TB] FAIL switch_pulse_width%0d: got %0d expected %0d", runs, run_len, exp_len); end
        run_len = 0;
      end
    end
    vectors++; if (runs != 2) begin miscompares++; $display("[TB] FAIL switch_pulses_seen: got %0d expected 2", runs); end
  endtask

  task automatic test_same_select();
    int used;
    $display("[TB] test_same_select");
    sel_in    = 3'd5;
    sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL same_setup_switching: got %b expected 1", switching); end
    wait_idle(600, used);
    vectors++; if (used >= 600) begin miscompares++; $display("[TB] FAIL same_setup_wait: got %0d cycles expected < 600", used); end
    vectors++; if (cur_sel !== 3'd5) begin miscompares++; $display("[TB] FAIL same_setup_cur_sel: got %0d expected 5", cur_sel); end
    sel_in    = 3'd5;
    sel_valid = 1'b1;
    vectors++; if (sel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL same_sel_ready_before: got %b expected 1", sel_ready); end
    step();
    sel_valid = 1'b0;
    vectors++; if (switching !== 1'b0) begin miscompares++; $display("[TB] FAIL same_switching: got %b expected 0", switching); end
    vectors++; if (sel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL same_sel_ready_after: got %b expected 1", sel_ready); end
    vectors++; if (cout !== edge_taps[5]) begin miscompares++; $display("[TB] FAIL same_cout_accept: got %b expected %b", cout, edge_taps[5]); end
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++; if (switching !== 1'b0) begin miscompares++; $display("[TB] FAIL same_switching[%0d]: got %b expected 0", i, switching); end
      vectors++; if (cout !== edge_taps[5]) begin miscompares++; $display("[TB] FAIL same_cout[%0d]: got %b expected %b", i, cout, edge_taps[5]); end
    end
    vectors++; if (cur_sel !== 3'd5) begin miscompares++; $display("[TB] FAIL same_cur_sel: got %0d expected 5", cur_sel); end
  endtask

  task automatic test_back_to_back();
    int n;
    int used;
    $display("[TB] test_back_to_back");
    sel_in    = 3'd1;
    sel_valid = 1'b1;
    step();
    sel_in = 3'd4;
    vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_switching: got %b expected 1", switching); end
    n = 0;
    while (switching === 1'b1 && n < 600) begin
      vectors++; if (cur_sel !== 3'd5) begin miscompares++; $display("[TB] FAIL b2b_hold_cur_sel[%0d]: got %0d expected 5", n, cur_sel); end
      step();
      n++;
    end
    vectors++; if (n >= 600) begin miscompares++; $display("[TB] FAIL b2b_first_wait: got %0d cycles expected < 600", n); end
    vectors++; if (cur_sel !== 3'd1) begin miscompares++; $display("[TB] FAIL b2b_first_cur_sel: got %0d expected 1", cur_sel); end
    vectors++; if (sel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready: got %b expected 1", sel_ready); end
    step();
    sel_valid = 1'b0;
    vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_switching: got %b expected 1", switching); end
    wait_idle(600, used);
    vectors++; if (used >= 600) begin miscompares++; $display("[TB] FAIL b2b_second_wait: got %0d cycles expected < 600", used); end
    vectors++; if (cur_sel !== 3'd4) begin miscompares++; $display("[TB] FAIL b2b_second_cur_sel: got %0d expected 4", cur_sel); end
  endtask

  task automatic test_timeout();
    $display("[TB] test_timeout");
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    force_ff = 1'b1;
    vectors++; if (cur_sel !== 3'd0) begin miscompares++; $display("[TB] FAIL tmo_start_cur_sel: got %0d expected 0", cur_sel); end
    sel_in    = 3'd3;
    sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_accept_switching: got %b expected 1", switching); end
    for (int k = 1; k <= 1025; k++) begin
      step();
      if (k == 511) begin
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_err_early: got %b expected 0", timeout_err); end
        vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_switching_511: got %b expected 1", switching); end
      end
      if (k == 512) begin
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err_set: got %b expected 1", timeout_err); end
        vectors++; if (cout !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_cout_512: got %b expected 1", cout); end
      end
      if (k >= 513 && k <= 1024) begin
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_new_low_cout[%0d]: got %b expected 0", k, cout); end
        vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_new_low_tick[%0d]: got %b expected 0", k, tick); end
      end
      if (k == 1023) begin
        vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_switching_1023: got %b expected 1", switching); end
        vectors++; if (cur_sel !== 3'd0) begin miscompares++; $display("[TB] FAIL tmo_cur_sel_1023: got %0d expected 0", cur_sel); end
      end
      if (k == 1024) begin
        vectors++; if (switching !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_switching_done: got %b expected 0", switching); end
        vectors++; if (cur_sel !== 3'd3) begin miscompares++; $display("[TB] FAIL tmo_cur_sel_done: got %0d expected 3", cur_sel); end
        vectors++; if (sel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_sel_ready_done: got %b expected 1", sel_ready); end
      end
      if (k == 1025) begin
        vectors++; if (cout !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_cout_new: got %b expected 1", cout); end
        vectors++; if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_tick_new: got %b expected 1", tick); end
      end
    end
    repeat (5) step();
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err_sticky: got %b expected 1", timeout_err); end
    vectors++; if (cur_sel !== 3'd3) begin miscompares++; $display("[TB] FAIL tmo_cur_sel_final: got %0d expected 3", cur_sel); end
  endtask

  task automatic test_reset_mid_switch();
    $display("[TB] test_reset_mid_switch");
    sel_in    = 3'd6;
    sel_valid = 1'b1;
    vectors++; if (sel_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_sel_ready_before: got %b expected 1", sel_ready); end
    step();
    sel_valid = 1'b0;
    // 512 cycles of WAIT_OLD_LOW then well into WAIT_NEW_LOW.
    repeat (520) step();
    vectors++; if (switching !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_switching: got %b expected 1", switching); end
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_cout: got %b expected 0", cout); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_err: got %b expected 1", timeout_err); end
    rst_n = 1'b0;
    step();
    vectors++; if (switching !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_switching: got %b expected 0", switching); end
    vectors++; if (cur_sel !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_rst_cur_sel: got %0d expected 0", cur_sel); end
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_cout: got %b expected 0", cout); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_tick: got %b expected 0", tick); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_err: got %b expected 0", timeout_err); end
    rst_n = 1'b1;
    step();
    vectors++; if (cur_sel !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_post_cur_sel: got %0d expected 0", cur_sel); end
    vectors++; if (switching !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_post_switching: got %b expected 0", switching); end
    vectors++; if (cout !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_post_cout: got %b expected 1", cout); end
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_post_tick: got %b expected 1", tick); end
    repeat (5) step();
    vectors++; if (cur_sel !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_discard_cur_sel: got %0d expected 0", cur_sel); end
    vectors++; if (switching !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_discard_switching: got %b expected 0", switching); end
    force_ff = 1'b0;
  endtask

  initial begin
    cnt            = 8'd0;
    force_ff       = 1'b0;
    rst_n          = 1'b0;
    sel_in         = 3'd0;
    sel_valid      = 1'b0;
    edge_taps      = 8'd0;
    prev_edge_taps = 8'd0;
    test_reset();
    test_steady();
    test_switch_2_to_7();
    test_same_select();
    test_back_to_back();
    test_timeout();
    test_reset_mid_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider_tap_select.md
# divider_tap_select

Glitch-free output selector sitting directly downstream of the 8-tap clock divider. It takes the eight divided-clock taps (÷2 … ÷256, all registered on `clk`) and forwards one of them on `cout`. A valid/ready request changes the selected tap without runt pulses, and `tick` gives a one-cycle pulse on each rising edge of `cout` for use as a clock-enable.

## Interface
- `NUM_TAPS`, 8: number of divider taps on `taps_in`.
- `SEL_W`, 3: select width, $clog2(NUM_TAPS).
- `RESET_SEL`, 0: tap selected out of reset.
- `TIMEOUT`, 512: maximum cycles spent in one wait state before a forced switch.

- `clk` in 1: the single clock; same clock that drives the divider.
- `rst_n` in 1: **synchronous, active-low** reset.
- `taps_in` in NUM_TAPS: divider outputs, bit i = ÷2^(i+1); synchronous to `clk`.
- `sel_in` in SEL_W: requested tap index.
- `sel_valid` in 1: request strobe.
- `sel_ready` out 1: request can be accepted this cycle.
- `cout` out 1: selected divided clock, registered.
- `tick` out 1: one-cycle pulse, high on the first cycle `cout` is high.
- `cur_sel` out SEL_W: tap currently driving `cout`.
- `switching` out 1: high while a switch is in progress.
- `timeout_err` out 1: sticky; a switch was forced by timeout.

## Operation
- States: RUN, WAIT_OLD_LOW, WAIT_NEW_LOW.
- `sel_ready` = (state == RUN) & `rst_n`. A request is accepted on a clock edge where `sel_valid` and `sel_ready` are both high.
- **RUN:**
  - `cout` <= `taps_in[cur_sel]`.
  - On an accepted request with `sel_in` == `cur_sel`: no-op, stay in RUN.
  - On an accepted request with `sel_in` != `cur_sel`: latch `pend_sel` <= `sel_in`, go to WAIT_OLD_LOW.
- **WAIT_OLD_LOW:**
  - `cout` <= `taps_in[cur_sel]`.
  - When `taps_in[cur_sel]` == 0, go to WAIT_NEW_LOW.
- **WAIT_NEW_LOW:**
  - `cout` <= 0.
  - When `taps_in[pend_sel]` == 0: `cur_sel` <= `pend_sel`, go to RUN.
- **Outputs:**
  - `switching` = state != RUN.
  - `tick` <= next_cout & ~`cout`, registered with `cout`.
  - `tick` is therefore never high in WAIT_NEW_LOW.
- **Wait timer:**
  - Cleared on entry to each wait state; increments every wait cycle.
  - At count TIMEOUT-1 the pending transition is taken unconditionally and `timeout_err` <= 1.
- `timeout_err` is cleared only by reset.
- `sel_in` values >= NUM_TAPS are accepted and treated as (`sel_in` mod NUM_TAPS).

## Timing
- Reset, evaluated on the clock edge while `rst_n`=0:
  - state = RUN, `cur_sel` = RESET_SEL, `pend_sel` = RESET_SEL.
  - `cout` = 0, `tick` = 0, `timeout_err` = 0, wait timer = 0.
- Latency: `cout` lags `taps_in[cur_sel]` by exactly 1 cycle in RUN and WAIT_OLD_LOW.
- Handshake:
  - `switching` rises the cycle after acceptance.
  - `sel_ready` is low from that cycle until the cycle after `cur_sel` updates.
- Glitch-free switch:
  - `cout` stays 0 for at least 1 cycle across the switch.
  - The last high pulse from the old tap and the first from the new tap each have full width.
- Reset during a wait state aborts the switch. The pending select is discarded and RESET_SEL is restored.
- A `sel_valid` held high while `sel_ready` is low is not accepted. It is taken in the first RUN cycle.

## Structure
- Package `divider_pkg`:
  - state enum `tap_sel_state_t` {RUN, WAIT_OLD_LOW, WAIT_NEW_LOW}.
  - NUM_TAPS/SEL_W defaults.
  - Timer width constant $clog2(TIMEOUT).
- One sub-module, `tap_wait_timer`:
  - Inputs: clear, enable.
  - Output: `expired` at TIMEOUT-1.
- The FSM, output mux and edge detect stay in the top.

## Test plan
Taps are driven by an 8-bit model counter with `taps_in[i]` = ~cnt[i].

1. **Reset.**
   - Stimulus: hold `rst_n`=0 for 3 cycles.
   - Response: `cout`=0, `tick`=0, `cur_sel`=0, `sel_ready`=0, `timeout_err`=0. `sel_ready`=1 on the first cycle after release.
2. **Steady state.**
   - Stimulus: select 2 (÷8).
   - Response: `cout` has period 8 with 4 cycles high and lags `taps_in[2]` by 1 cycle. `tick` pulses once per 8 cycles, coincident with the `cout` rise.
3. **Switch 2→7 while `taps_in[2]`=1.**
   - `switching`=1 and `sel_ready`=0 until the switch completes.
   - `cout` finishes its 4-high pulse, then stays 0 until `taps_in[7]` is low; `cur_sel`=7.
   - No `cout` high pulse is shorter than 4 cycles; no `tick` occurs while in WAIT_NEW_LOW.
4. **Same-select request.**
   - Stimulus: request `sel_in`=`cur_sel`=5.
   - Response: accepted in 1 cycle; `switching` stays 0; `cout` is uninterrupted.
5. **Timeout.**
   - Stimulus: hold `taps_in`=8'hFF and request 0→3.
   - Response: forced exit from WAIT_OLD_LOW after 512 cycles and from WAIT_NEW_LOW after another 512. `cur_sel`=3 and `timeout_err`=1, which stays set until reset.
6. **Reset mid-switch.**
   - Stimulus: drop `rst_n` during WAIT_NEW_LOW.
   - Response: on the next edge state=RUN, `cur_sel`=RESET_SEL, `cout`=0, `switching`=0, `timeout_err`=0.
